bcd_disp_scan: RTL and testbench
================================

Name: bcd_disp_scan

Overview:
- Downstream consumer of the three-digit BCD counter outputs (units u, tens d, hundreds c).
- Drives a 3-digit common-anode multiplexed 7-segment display: time-multiplexes the digits with a refresh prescaler.
- Snapshots the digits once per frame so a frame never mixes old and new counts (no tearing).
- Inserts anode guard time between slots (anti-ghosting), blanks leading zeros, shows a dash for non-BCD codes.

Parameters:
- CLK_DIV, 50000: clocks per digit slot; legal range >= 2; internal counter width $clog2(CLK_DIV).
- GUARD, 2: clocks at the start of each slot with all anodes off; legal range 0 <= GUARD < CLK_DIV.
- BLANK_LZ, 1: 1 = leading-zero blanking on, 0 = off.
- SEG_ACTIVE_LOW, 1: 1 = seg outputs inverted (lit = 0).
- AN_ACTIVE_LOW, 1: 1 = an outputs inverted (selected = 0).

Ports:
- clk, in, 1: single clock; all logic runs on the rising edge.
- rst, in, 1: asynchronous, active-low reset (0 = reset).
- en, in, 1: scan enable; 0 = freeze scan state and blank the display.
- u, in, 4: units digit (BCD).
- d, in, 4: tens digit (BCD).
- c, in, 4: hundreds digit (BCD).
- seg, out, 7: segments {g,f,e,d,c,b,a}.
- an, out, 3: anodes; an[0] = units, an[1] = tens, an[2] = hundreds.
- frm, out, 1: one-clock pulse after each snapshot capture.

Behaviour:
Internal state
- cnt: prescaler counter.
- sel: slot select, 0 = U, 1 = D, 2 = C.
- su, sd, sc: snapshot registers.
- tick = en && (cnt == CLK_DIV-1).

Reset (rst = 0, immediate, asynchronous)
- cnt = 0, sel = 0, su = sd = sc = 0, frm = 0.
- an = all inactive (3'b111 when AN_ACTIVE_LOW).
- seg = all off (7'h7F when SEG_ACTIVE_LOW).
- Asserting reset mid-scan aborts the frame; on release, scanning restarts at slot U with cnt = 0.

Prescaler
- en = 1: cnt increments each clock and wraps CLK_DIV-1 -> 0.
- en = 0: cnt holds.

Slot select
- On tick: sel advances 0 -> 1 -> 2 -> 0. No other transitions; sel = 3 is unreachable and treated as 0.

Snapshot
- On tick with sel == 2: {sc, sd, su} <= {c, d, u}. Inputs are sampled only then.
- Input changes at any other time have no visible effect until the next capture.

Outputs (registered, 1-clock latency)
- Outputs after edge k are computed from the cnt/sel/snapshot/en values present after edge k-1.
- an: the bit for sel is active iff en = 1 and cnt >= GUARD; all other bits are inactive.
- seg: decodes the snapshot digit for sel.
  - 0-9 use the active-high patterns 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - 10-15 decode to dash 40.
  - Pattern is inverted when SEG_ACTIVE_LOW.
  - seg is all off whenever en = 0.
- frm: 1 for exactly one clock, in the cycle after a capture edge.

Leading-zero blanking (BLANK_LZ = 1)
- Hundreds slot: blank when sc == 0.
- Tens slot: blank when sc == 0 and sd == 0.
- Units slot: never blanked.
- Blanked slot: seg all off, anode still driven normally.
- Dash codes count as nonzero.

Enable
- en falling: display goes inactive one clock later; cnt, sel and snapshot hold.
- en rising: scanning resumes from the held cnt/sel.

Test Plan (CLK_DIV = 4, GUARD = 1, all other parameters default)
1. Reset: hold rst = 0 with en = 1 and random digits -> an = 3'b111, seg = 7'h7F, frm = 0 throughout; rst = 0 asserted mid-slot forces the same values without waiting for a clock edge.
2. Scan order and latency: release reset, en = 1, u = 3, d = 2, c = 1.
   - First frame: U slot shows 0 (seg = 7'h40); D and C slots are blanked (7'h7F).
   - After the first frm: U slot an = 3'b110, seg = 7'h30; D slot an = 3'b101, seg = 7'h24; C slot an = 3'b011, seg = 7'h79.
   - Each slot lasts exactly 4 clocks.
3. Guard: in every slot, the first clock has an = 3'b111; the next 3 clocks have the single selected bit active; frm pulses once every 12 clocks.
4. Leading-zero blanking:
   - c = 0, d = 0, u = 7 -> C and D slots seg = 7'h7F, U slot seg = 7'h78.
   - c = 0, d = 5, u = 0 -> D slot seg = 7'h12, U slot seg = 7'h40, C slot blank.
   - With BLANK_LZ = 0, C shows 0 (7'h40).
5. Invalid code and snapshot stability:
   - u = 4'hC -> U slot seg = 7'h3F.
   - Change u from 3 to 8 during the D slot -> U slot keeps 7'h30 until after the next frm, then shows 7'h00.
6. Enable: drop en for 10 clocks mid-D-slot -> an = 3'b111, seg = 7'h7F from one clock after the drop; on re-enable, the D slot resumes with the remaining cnt count and no frm glitch.

Source files
------------

// File: rtl/bcd_disp_scan.sv
// Three-digit multiplexed 7-segment scanner for a BCD counter.
// Digits are captured once per frame so one frame never mixes old and
// new counts. Each slot opens with a short all-anodes-off guard
// interval. Leading zeros can be blanked, and non-BCD codes show a dash.
module bcd_disp_scan #(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned GUARD          = 2,
  parameter int unsigned BLANK_LZ       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] u,
  input  logic [3:0] d,
  input  logic [3:0] c,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frm
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [2:0]    AN_OFF  = (AN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
  localparam logic [6:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    SEL_U = 2'd0,
    SEL_D = 2'd1,
    SEL_C = 2'd2
  } sel_e;

  logic [CW-1:0] cnt_q, cnt_d;
  sel_e          sel_q, sel_d;
  logic [3:0]    su_q, su_d;
  logic [3:0]    sd_q, sd_d;
  logic [3:0]    sc_q, sc_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          frm_q, frm_d;

  logic          tick;
  logic [3:0]    digit;
  logic          blank;
  logic [2:0]    an_one;
  logic [2:0]    an_act;
  logic [6:0]    seg_act;
  logic          guard_ok;

  // Active-high {g,f,e,d,c,b,a} pattern; anything above 9 becomes a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  // Prescaler, slot advance, frame snapshot and frame pulse.
  always_comb begin
    tick  = en && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    sel_d = sel_q;
    su_d  = su_q;
    sd_d  = sd_q;
    sc_d  = sc_q;
    frm_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      case (sel_q)
        SEL_D:   sel_d = SEL_C;
        SEL_C:   sel_d = SEL_U;
        default: sel_d = SEL_D;
      endcase
      if (sel_q == SEL_C) begin
        su_d  = u;
        sd_d  = d;
        sc_d  = c;
        frm_d = 1'b1;
      end
    end
  end

  // Digit select, guard, blanking and polarity for the registered outputs.
  always_comb begin
    case (sel_q)
      SEL_D: begin
        digit  = sd_q;
        blank  = (BLANK_LZ != 0) && (sc_q == 4'd0) && (sd_q == 4'd0);
        an_one = 3'b010;
      end
      SEL_C: begin
        digit  = sc_q;
        blank  = (BLANK_LZ != 0) && (sc_q == 4'd0);
        an_one = 3'b100;
      end
      default: begin
        digit  = su_q;
        blank  = 1'b0;
        an_one = 3'b001;
      end
    endcase
    guard_ok = (GUARD == 0) || (cnt_q >= GUARD_C);
    an_act   = (en && guard_ok) ? an_one : '0;
    seg_act  = (en && !blank) ? seg_decode(digit) : '0;
    an_d     = (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
    seg_d    = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
  end

  // State and output registers, asynchronously cleared by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sel_q <= SEL_U;
      su_q  <= '0;
      sd_q  <= '0;
      sc_q  <= '0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      frm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      su_q  <= su_d;
      sd_q  <= sd_d;
      sc_q  <= sc_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      frm_q <= frm_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign frm = frm_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed bench for bcd_disp_scan with CLK_DIV=4, GUARD=1. A second
// instance with BLANK_LZ=0 shares all inputs.
module tb_bcd_disp_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [3:0] u   = '0;
  logic [3:0] d   = '0;
  logic [3:0] c   = '0;
  logic [6:0] seg0, seg1;
  logic [2:0] an0, an1;
  logic       frm0, frm1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  bcd_disp_scan #(.CLK_DIV(4), .GUARD(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .u(u), .d(d), .c(c),
    .seg(seg0), .an(an0), .frm(frm0)
  );

  bcd_disp_scan #(.CLK_DIV(4), .GUARD(1), .BLANK_LZ(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .u(u), .d(d), .c(c),
    .seg(seg1), .an(an1), .frm(frm1)
  );

  always #5 clk = ~clk;

  // Expected anodes for a slot (0=U,1=D,2=C) at clock p within the slot.
  function automatic logic [2:0] an_for(input int slot, input int p);
    if (p == 0) return 3'b111;
    case (slot)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic chk_now(input string tag, input logic [2:0] ea,
                         input logic [6:0] es0, input logic [6:0] es1,
                         input logic ef);
    checks++;
    assert (an0 === ea) else begin
      errors++;
      $error("FAIL %s edge %0d an0 got %b exp %b", tag, edge_n, an0, ea);
    end
    checks++;
    assert (an1 === ea) else begin
      errors++;
      $error("FAIL %s edge %0d an1 got %b exp %b", tag, edge_n, an1, ea);
    end
    checks++;
    assert (seg0 === es0) else begin
      errors++;
      $error("FAIL %s edge %0d seg0 got %h exp %h", tag, edge_n, seg0, es0);
    end
    checks++;
    assert (seg1 === es1) else begin
      errors++;
      $error("FAIL %s edge %0d seg1 got %h exp %h", tag, edge_n, seg1, es1);
    end
    checks++;
    assert (frm0 === ef) else begin
      errors++;
      $error("FAIL %s edge %0d frm0 got %b exp %b", tag, edge_n, frm0, ef);
    end
    checks++;
    assert (frm1 === ef) else begin
      errors++;
      $error("FAIL %s edge %0d frm1 got %b exp %b", tag, edge_n, frm1, ef);
    end
  endtask

  task automatic step_chk(input string tag, input logic [2:0] ea,
                          input logic [6:0] es0, input logic [6:0] es1,
                          input logic ef);
    @(posedge clk);
    #1;
    edge_n++;
    chk_now(tag, ea, es0, es1, ef);
  endtask

  // One 12-clock frame; optionally changes u right after clock chg_at.
  task automatic run_frame(input string tag,
                           input logic [6:0] e0u, input logic [6:0] e0d,
                           input logic [6:0] e0c,
                           input logic [6:0] e1u, input logic [6:0] e1d,
                           input logic [6:0] e1c,
                           input int chg_at, input logic [3:0] chg_u);
    for (int i = 1; i <= 12; i++) begin
      int slot;
      int p;
      logic [6:0] s0, s1;
      slot = (i - 1) / 4;
      p    = (i - 1) % 4;
      s0 = (slot == 0) ? e0u : (slot == 1) ? e0d : e0c;
      s1 = (slot == 0) ? e1u : (slot == 1) ? e1d : e1c;
      step_chk(tag, an_for(slot, p), s0, s1, (i == 12));
      if (i == chg_at) u = chg_u;
    end
  endtask

  initial begin
    // Reset held with enable on and arbitrary digits.
    for (int i = 0; i < 3; i++) begin
      u = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      step_chk("reset_hold", 3'b111, 7'h7F, 7'h7F, 1'b0);
    end

    u = 4'd3; d = 4'd2; c = 4'd1;
    rst = 1'b1;

    // First frame shows the cleared snapshot; then 1,2,3.
    run_frame("frame0", 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 0, 4'd0);
    run_frame("frame1", 7'h30, 7'h24, 7'h79, 7'h30, 7'h24, 7'h79, 0, 4'd0);

    // u changes during the D slot; only the next frame picks it up.
    run_frame("snap_d",  7'h30, 7'h24, 7'h79, 7'h30, 7'h24, 7'h79, 6, 4'd8);
    // u changes while U is on screen; the shown digit must not move.
    run_frame("snap_u8", 7'h00, 7'h24, 7'h79, 7'h00, 7'h24, 7'h79, 2, 4'hC);
    run_frame("dash",    7'h3F, 7'h24, 7'h79, 7'h3F, 7'h24, 7'h79, 2, 4'd3);
    run_frame("back3",   7'h30, 7'h24, 7'h79, 7'h30, 7'h24, 7'h79, 0, 4'd0);

    // Enable dropped for 10 clocks two clocks into the D slot.
    for (int i = 1; i <= 6; i++) begin
      int slot;
      logic [6:0] s;
      slot = (i - 1) / 4;
      s = (slot == 0) ? 7'h30 : 7'h24;
      step_chk("en_pre", an_for(slot, (i - 1) % 4), s, s, 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_chk("en_off", 3'b111, 7'h7F, 7'h7F, 1'b0);
    end
    en = 1'b1;
    step_chk("en_resume", 3'b101, 7'h24, 7'h24, 1'b0);
    step_chk("en_resume", 3'b101, 7'h24, 7'h24, 1'b0);
    for (int p = 0; p < 4; p++) begin
      step_chk("en_c", an_for(2, p), 7'h79, 7'h79, (p == 3));
    end

    // Leading-zero blanking.
    u = 4'd7; d = 4'd0; c = 4'd0;
    run_frame("lz_old", 7'h30, 7'h24, 7'h79, 7'h30, 7'h24, 7'h79, 0, 4'd0);
    u = 4'd0; d = 4'd5; c = 4'd0;
    run_frame("lz_007", 7'h78, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40, 0, 4'd0);
    run_frame("lz_050", 7'h40, 7'h12, 7'h7F, 7'h40, 7'h12, 7'h40, 0, 4'd0);

    // Asynchronous reset in the middle of the U slot.
    step_chk("ar_pre", 3'b111, 7'h40, 7'h40, 1'b0);
    step_chk("ar_pre", 3'b110, 7'h40, 7'h40, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk_now("ar_async", 3'b111, 7'h7F, 7'h7F, 1'b0);
    step_chk("ar_hold", 3'b111, 7'h7F, 7'h7F, 1'b0);
    step_chk("ar_hold", 3'b111, 7'h7F, 7'h7F, 1'b0);
    rst = 1'b1;
    run_frame("ar_f0", 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 0, 4'd0);
    run_frame("ar_f1", 7'h40, 7'h12, 7'h7F, 7'h40, 7'h12, 7'h40, 0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
